in_dispatcher: RTL
==================

Name: in_dispatcher

Overview:
Ingress counterpart of the multicore output arbiter. Accepts the single 64-bit data/8-bit ctrl packet stream from the datapath and store-and-forwards whole packets to one of 4 processing cores, chosen round-robin. Cores are reached over a req/ack/bop/eop/wr/rdy handshake. One shared data bus feeds all cores, qualified by per-core wr.

Parameters:
FIFO_DEPTH, 256, words in packet buffer (power of 2; usedw width = log2(FIFO_DEPTH)).
FULL_MARGIN, 8, in_rdy deasserts when free words < FULL_MARGIN.
ACK_TIMEOUT, 64, cycles to wait for a core's ack before skipping to the next core.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-low reset.
in_data  in  64  ingress word.
in_ctrl  in  8  8'hFF = first word (bop); any other nonzero value = last word (eop); 0 = middle.
in_wr  in  1  ingress word valid.
in_rdy  out  1  dispatcher can accept words.
out_data  out  64  shared word bus to all cores.
out_bop  out  1  out_data is the first word of a packet.
out_eop  out  1  out_data is the last word of a packet.
out_wr  out  4  per-core word strobe; at most one bit set.
out_req  out  4  per-core packet offer; at most one bit set.
out_ack  in  4  per-core acceptance of the offer.
out_rdy  in  4  per-core can accept a word next cycle.

Behaviour:
- Reset (reset==0 at a clk edge):
  - out_req=0, out_wr=0, out_data=0, out_bop=0, out_eop=0, in_rdy=0.
  - FIFO cleared, pkt_cnt=0, rr_ptr=0, state=IDLE.
  - Reset mid-packet simply drops the req; a core must discard a partial packet on req falling before eop.
- Ingress:
  - in_rdy = (free words >= FULL_MARGIN), registered; forced 0 in reset.
  - in_wr writes {in_ctrl,in_data} to the FIFO.
  - Upstream may issue up to FULL_MARGIN-1 writes after in_rdy falls.
  - A write when the FIFO is full is dropped and sets internal sticky flag ovf (cleared by reset only).
- pkt_cnt:
  - +1 on a written eop word; -1 on a read eop word.
  - Both in the same cycle: unchanged.
  - Width log2(FIFO_DEPTH)+1; never wraps.
- FSM:
  - IDLE: if pkt_cnt!=0, set cur=rr_ptr, assert out_req[cur], load timer=ACK_TIMEOUT, go REQ.
  - REQ: hold out_req[cur].
    - out_ack[cur]==1: go TX.
    - timer reaches 0: drop req, rr_ptr=cur+1 (3 wraps to 0), go IDLE.
  - TX: hold out_req[cur]; out_ack is ignored.
    - Read the FIFO in any cycle with !empty && out_rdy[cur].
    - On reading the eop word, stop reading and go DONE.
  - DONE: one cycle, lets the final out_wr issue. Deassert out_req[cur] at exit, rr_ptr=cur+1 mod 4, go IDLE.
  - Back-to-back packets: earliest next req is 1 cycle after DONE.
- Output timing: FIFO read latency 1. For a read in cycle N, cycle N+1 carries out_wr[cur]=1 with out_data/out_bop/out_eop for that word. out_wr is 0 otherwise.
- out_rdy[cur] dropping mid-packet stalls reads with no word loss. Other cores' out_rdy is ignored.
- A packet is never dispatched before its eop word is buffered, so the FIFO never underruns mid-packet.

Decomposition:
- Shared package: CTRL_BOP=8'hFF; eop = nonzero ctrl other than CTRL_BOP; NUM_CORES=4; FSM state encoding {IDLE,REQ,TX,DONE}.
- One sub-module: dispatch_fifo.
  - 72-bit synchronous FIFO, FIFO_DEPTH deep.
  - Ports: data, wrreq, rdreq, q (1-cycle latency), empty, full, usedw, sclr.
  - sclr is driven by !reset.

Test Plan:
- 3-word packet (FF/00/01 ctrl, data 0x11,0x22,0x33), all cores ack immediately, all rdy=1 -> out_req[0] rises 1 cycle after eop write; 3 consecutive out_wr[0] pulses, bop on 0x11, eop on 0x33; req drops after DONE.
- 5 one-word-header packets back-to-back -> cores served 0,1,2,3,0; no overlap of out_req bits; pkt_cnt returns to 0.
- Core 1 never acks, ACK_TIMEOUT=64 -> out_req[1] high exactly 64 cycles, then out_req[2] asserted; packet delivered to core 2.
- out_rdy[0] low for 10 cycles mid-packet of 8 words -> out_wr[0] gap of 10 cycles, all 8 words in order, none lost or duplicated.
- Fill FIFO with FIFO_DEPTH=256, FULL_MARGIN=8, no core ack -> in_rdy falls at 249 used words; the 257th write sets ovf; after ack, all stored complete packets delivered.
- reset=0 asserted mid-TX at word 4 of 8 -> next cycle out_req=0, out_wr=0, in_rdy=0; after release, pkt_cnt=0 and a new packet goes to core 0.

Source files
------------

// File: rtl/in_dispatcher_pkg.sv
// Shared types and helpers for the ingress packet dispatcher.
// Ctrl byte decoding, core selection and FSM encoding live here.
package in_dispatcher_pkg;

  localparam int unsigned DATA_W    = 64;
  localparam int unsigned CTRL_W    = 8;
  localparam int unsigned WORD_W    = DATA_W + CTRL_W;
  localparam int unsigned NUM_CORES = 4;
  localparam int unsigned CORE_W    = 2;

  localparam logic [CTRL_W-1:0] CTRL_BOP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    TX   = 2'd2,
    DONE = 2'd3
  } state_t;

  // One buffered ingress word: ctrl byte on top, payload below.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } word_t;

  function automatic logic is_bop(input logic [CTRL_W-1:0] ctrl);
    return ctrl == CTRL_BOP;
  endfunction

  // Any nonzero ctrl other than the bop marker closes a packet.
  function automatic logic is_eop(input logic [CTRL_W-1:0] ctrl);
    return (ctrl != '0) && (ctrl != CTRL_BOP);
  endfunction

  function automatic logic [NUM_CORES-1:0] core_bit(input logic [CORE_W-1:0] idx);
    return NUM_CORES'(1) << idx;
  endfunction

endpackage

// File: rtl/dispatch_fifo.sv
// Synchronous single-clock FIFO with registered read data (1-cycle latency)
// plus a combinational peek at the top bits of the head word.
module dispatch_fifo #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WIDTH  = 72,
  parameter int unsigned HEAD_W = 8
) (
  input  logic                     clk,
  input  logic                     sclr,
  input  logic [WIDTH-1:0]         data,
  input  logic                     wrreq,
  input  logic                     rdreq,
  output logic [WIDTH-1:0]         q,
  output logic [HEAD_W-1:0]        head_c,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH)-1:0] usedw
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_wr;
  logic             do_rd;
  logic [WIDTH-1:0] head_word;

  assign do_wr     = wrreq && !full;
  assign do_rd     = rdreq && !empty;
  assign count_nxt = count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
  assign usedw     = count[AW-1:0];
  assign head_word = mem[rd_ptr];
  assign head_c    = head_word[WIDTH-1 -: HEAD_W];

  // Storage array carries no reset; only pointers and flags are cleared.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      q      <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr <= rd_ptr + AW'(1);
        q      <= head_word;
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == (AW+1)'(DEPTH));
    end
  end

endmodule

// File: rtl/in_dispatcher.sv
// Store-and-forward ingress dispatcher: buffers whole packets and hands each
// one to the next processing core in round-robin order over req/ack/wr/rdy.
module in_dispatcher
  import in_dispatcher_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 256,
  parameter int unsigned FULL_MARGIN = 8,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    in_data,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic                 in_wr,
  output logic                 in_rdy,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_bop,
  output logic                 out_eop,
  output logic [NUM_CORES-1:0] out_wr,
  output logic [NUM_CORES-1:0] out_req,
  input  logic [NUM_CORES-1:0] out_ack,
  input  logic [NUM_CORES-1:0] out_rdy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  word_t             wr_word;
  word_t             rd_word;
  logic [CTRL_W-1:0] head_ctrl_c;
  logic              fifo_empty;
  logic              fifo_full;
  logic [AW-1:0]     fifo_usedw;
  logic [AW:0]       used;
  logic [AW:0]       free;
  logic              fifo_rd_c;
  logic              wr_eop_c;
  logic              rd_eop_c;

  state_t            state;
  logic [CORE_W-1:0] cur;
  logic [CORE_W-1:0] rr_ptr;
  logic [TW-1:0]     timer;
  logic [AW:0]       pkt_cnt;
  logic              ovf;

  assign wr_word = '{ctrl: in_ctrl, data: in_data};

  dispatch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (WORD_W),
    .HEAD_W (CTRL_W)
  ) u_fifo (
    .clk    (clk),
    .sclr   (!reset),
    .data   (wr_word),
    .wrreq  (in_wr),
    .rdreq  (fifo_rd_c),
    .q      (rd_word),
    .head_c (head_ctrl_c),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .usedw  (fifo_usedw)
  );

  // usedw wraps to zero at full, so the full flag supplies the top bit.
  assign used = {fifo_full, fifo_usedw};
  assign free = (AW+1)'(FIFO_DEPTH) - used;

  // Reads stop on the eop word, so a read never strays into the next packet.
  assign fifo_rd_c = (state == TX) && !fifo_empty && out_rdy[cur];
  assign wr_eop_c  = in_wr && !fifo_full && is_eop(in_ctrl);
  assign rd_eop_c  = fifo_rd_c && is_eop(head_ctrl_c);

  assign out_data = rd_word.data;
  assign out_bop  = is_bop(rd_word.ctrl);
  assign out_eop  = is_eop(rd_word.ctrl);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cur     <= '0;
      rr_ptr  <= '0;
      timer   <= '0;
      out_req <= '0;
      out_wr  <= '0;
      in_rdy  <= 1'b0;
      pkt_cnt <= '0;
      ovf     <= 1'b0;
    end else begin
      in_rdy <= (free >= (AW+1)'(FULL_MARGIN));
      if (in_wr && fifo_full) ovf <= 1'b1;

      if (wr_eop_c && !rd_eop_c)      pkt_cnt <= pkt_cnt + (AW+1)'(1);
      else if (rd_eop_c && !wr_eop_c) pkt_cnt <= pkt_cnt - (AW+1)'(1);

      // Strobe lines up with the FIFO's registered read data.
      out_wr <= fifo_rd_c ? core_bit(cur) : '0;

      case (state)
        IDLE: begin
          if (pkt_cnt != '0) begin
            cur     <= rr_ptr;
            out_req <= core_bit(rr_ptr);
            timer   <= TW'(ACK_TIMEOUT);
            state   <= REQ;
          end
        end
        REQ: begin
          if (out_ack[cur]) begin
            state <= TX;
          end else if (timer <= TW'(1)) begin
            out_req <= '0;
            rr_ptr  <= cur + CORE_W'(1);
            state   <= IDLE;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        TX: begin
          if (rd_eop_c) state <= DONE;
        end
        DONE: begin
          out_req <= '0;
          rr_ptr  <= cur + CORE_W'(1);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
